// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: opcode encodings,
// top-level FSM states and the registered flag bundle.
package alu_pkg;

  localparam logic [5:0] OP_ADDR  = 6'b000000;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_XOR   = 6'b010001;
  localparam logic [5:0] OP_ADD   = 6'b010010;
  localparam logic [5:0] OP_MULTU = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b010100;
  localparam logic [5:0] OP_NEG   = 6'b010101;
  localparam logic [5:0] OP_SRL   = 6'b010110;
  localparam logic [5:0] OP_SLL   = 6'b010111;
  localparam logic [5:0] OP_SRA   = 6'b011000;
  localparam logic [5:0] OP_ADDI  = 6'b100000;
  localparam logic [5:0] OP_NEGI  = 6'b100001;
  localparam logic [5:0] OP_SRLI  = 6'b100010;
  localparam logic [5:0] OP_SLLI  = 6'b100011;
  localparam logic [5:0] OP_SRAI  = 6'b100100;
  localparam logic [5:0] OP_PASSA = 6'b110000;
  localparam logic [5:0] OP_PASSB = 6'b110001;

  typedef enum logic [1:0] {IDLE, MUL, SIGN} state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic s;
    logic o;
  } flags_t;

  function automatic logic is_mul(input logic [5:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the EX-stage controller (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [15:0]      imm;
  logic [5:0]       control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_mult;
  logic             c_flag;
  logic             z_flag;
  logic             s_flag;
  logic             o_flag;

  modport master (
    output start, a, b, imm, control,
    input  busy, done, res, res_mult, c_flag, z_flag, s_flag, o_flag
  );

  modport slave (
    input  start, a, b, imm, control,
    output busy, done, res, res_mult, c_flag, z_flag, s_flag, o_flag
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier on operand magnitudes; one multiplier bit per
// cycle. The unsigned 2*WIDTH magnitude product and the sign to apply are outputs.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic               neg_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               neg_q, neg_d;
  logic [WIDTH:0]     sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    neg_d    = neg_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    if (start_i) begin
      // Magnitudes are plain unsigned W-bit values, so -2^(W-1) maps to 2^(W-1).
      mcand_d  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      mplier_d = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
      neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (run_q) begin
      acc_d    = {sum, acc_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) run_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      neg_q    <= neg_d;
    end
  end

  // High during the final step; prod_o is complete after that edge.
  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign neg_o  = neg_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle datapath registered at accept, plus an
// IDLE -> MUL -> SIGN sequence around mul_seq for MULTU/MULT.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int IW  = (WIDTH < 16) ? WIDTH : 16;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_mult_q, res_mult_d;
  flags_t             flags_q, flags_d;
  logic               done_q, done_d;

  logic               mul_start, mul_done, mul_neg;
  logic [2*WIDTH-1:0] prod, prod_fix;

  logic [WIDTH-1:0]   imm_x, alu_res;
  logic               alu_c, alu_o;
  logic [SHW-1:0]     sh_b, sh_i;

  assign sh_b     = bus.b[SHW-1:0];
  assign sh_i     = bus.imm[SHW-1:0];
  assign prod_fix = mul_neg ? -prod : prod;

  always_comb begin
    imm_x         = '0;
    imm_x[IW-1:0] = bus.imm[IW-1:0];
  end

  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    unique case (bus.control)
      OP_AND:   alu_res = bus.a & bus.b;
      OP_XOR:   alu_res = bus.a ^ bus.b;
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, bus.a} + {1'b0, bus.b};
        alu_o = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NEG:   alu_res = -bus.b;
      OP_SRL:   alu_res = bus.a >> sh_b;
      OP_SLL:   alu_res = bus.a << sh_b;
      OP_SRA:   alu_res = $signed(bus.a) >>> sh_b;
      OP_ADDI: begin
        {alu_c, alu_res} = {1'b0, bus.a} + {1'b0, imm_x};
        alu_o = ~bus.a[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_NEGI:  alu_res = -imm_x;
      OP_SRLI:  alu_res = bus.a >> sh_i;
      OP_SLLI:  alu_res = bus.a << sh_i;
      OP_SRAI:  alu_res = $signed(bus.a) >>> sh_i;
      OP_ADDR:  alu_res = bus.a + imm_x;
      OP_PASSA: alu_res = bus.a;
      OP_PASSB: alu_res = bus.b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_mult_d = res_mult_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    mul_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_mul(bus.control)) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            res_d      = alu_res;
            res_mult_d = '0;
            flags_d    = '{c: alu_c, z: (alu_res == '0), s: alu_res[WIDTH-1], o: alu_o};
            done_d     = 1'b1;
          end
        end
      end
      MUL: if (mul_done) state_d = SIGN;
      SIGN: begin
        {res_mult_d, res_d} = prod_fix;
        flags_d = '{c: 1'b0, z: (prod_fix == '0), s: prod_fix[2*WIDTH-1], o: 1'b0};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      res_q      <= '0;
      res_mult_q <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_mult_q <= res_mult_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
    end
  end

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .signed_i (bus.control == OP_MULT),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (mul_done),
    .neg_o    (mul_neg),
    .prod_o   (prod)
  );

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.res      = res_q;
  assign bus.res_mult = res_mult_q;
  assign bus.c_flag   = flags_q.c;
  assign bus.z_flag   = flags_q.z;
  assign bus.s_flag   = flags_q.s;
  assign bus.o_flag   = flags_q.o;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=8; flags are compared as {c,z,s,o}.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] fl32();
    return {bus32.c_flag, bus32.z_flag, bus32.s_flag, bus32.o_flag};
  endfunction

  function automatic logic [3:0] fl8();
    return {bus8.c_flag, bus8.z_flag, bus8.s_flag, bus8.o_flag};
  endfunction

  task automatic issue32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm);
    bus32.control = op;
    bus32.a       = a;
    bus32.b       = b;
    bus32.imm     = imm;
    bus32.start   = 1'b1;
    tick();
    bus32.start   = 1'b0;
  endtask

  task automatic issue8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] imm);
    bus8.control = op;
    bus8.a       = a;
    bus8.b       = b;
    bus8.imm     = imm;
    bus8.start   = 1'b1;
    tick();
    bus8.start   = 1'b0;
  endtask

  // Single op: done and the result must be visible one cycle after accept.
  task automatic sop(input string tag, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [15:0] imm,
                     input logic [31:0] exp_res, input logic [3:0] exp_fl);
    issue32(op, a, b, imm);
    check({tag, " done"}, bus32.done, 1'b1);
    check({tag, " res"}, bus32.res, exp_res);
    check({tag, " flags"}, fl32(), exp_fl);
  endtask

  // n counts cycles from the accept edge (n=1 right after it) until done.
  task automatic wait32(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (bus32.done !== 1'b1 && n < 100) begin
      if (bus32.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic wait8(output int n);
    n = 1;
    while (bus8.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic busy_ok;
    logic saw_done;

    rst = 1'b1;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.imm = '0; bus32.control = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.imm  = '0; bus8.control  = '0;
    tick();
    tick();
    check("reset res", bus32.res, 32'h0);
    check("reset res_mult", bus32.res_mult, 32'h0);
    check("reset busy/done", {bus32.busy, bus32.done}, 2'b00);
    check("reset flags", fl32(), 4'b0000);
    rst = 1'b0;
    tick();

    sop("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 16'h0, 32'h8000_0000, 4'b0011);
    check("add ovf res_mult", bus32.res_mult, 32'h0);
    sop("add carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 16'h0, 32'h0, 4'b1100);
    sop("b2b sra", OP_SRA, 32'h8000_0000, 32'h4, 16'h0, 32'hF800_0000, 4'b0010);
    tick();
    check("done pulse ends", bus32.done, 1'b0);
    check("res holds", bus32.res, 32'hF800_0000);
    check("flags hold", fl32(), 4'b0010);

    sop("and",   OP_AND,   32'hF0F0_1234, 32'h0FF0_FF00, 16'h0,    32'h00F0_1200, 4'b0000);
    sop("xor",   OP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0,    32'hF0F0_0F0F, 4'b0010);
    sop("neg",   OP_NEG,   32'h0,         32'h1,         16'h0,    32'hFFFF_FFFF, 4'b0010);
    sop("srl",   OP_SRL,   32'h8000_0000, 32'h21,        16'h0,    32'h4000_0000, 4'b0000);
    sop("sll",   OP_SLL,   32'h1,         32'h1F,        16'h0,    32'h8000_0000, 4'b0010);
    sop("addi c", OP_ADDI, 32'hFFFF_FFFF, 32'h0,         16'h0001, 32'h0,         4'b1100);
    sop("addi o", OP_ADDI, 32'h7FFF_FFFF, 32'h0,         16'h0001, 32'h8000_0000, 4'b0011);
    sop("negi",  OP_NEGI,  32'h0,         32'h0,         16'h0010, 32'hFFFF_FFF0, 4'b0010);
    sop("srli",  OP_SRLI,  32'hF000_0000, 32'h0,         16'h0004, 32'h0F00_0000, 4'b0000);
    sop("slli",  OP_SLLI,  32'h3,         32'h0,         16'hFFE2, 32'hC,         4'b0000);
    sop("srai",  OP_SRAI,  32'h8000_0000, 32'h0,         16'h001F, 32'hFFFF_FFFF, 4'b0010);
    sop("addr",  OP_ADDR,  32'hFFFF_FFFF, 32'h0,         16'h0001, 32'h0,         4'b0100);
    sop("passa", OP_PASSA, 32'h1234_5678, 32'h0,         16'h0,    32'h1234_5678, 4'b0000);
    sop("passb", OP_PASSB, 32'h0,         32'h8000_0001, 16'h0,    32'h8000_0001, 4'b0010);
    sop("undef", 6'b111111, 32'h5,        32'h5,         16'h5,    32'h0,         4'b0100);

    // multu with operand changes after accept and an ignored start mid-operation.
    issue32(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 16'h0);
    bus32.a = 32'h0;
    bus32.b = 32'h0;
    lat = 1;
    busy_ok = 1'b1;
    while (bus32.done !== 1'b1 && lat < 100) begin
      if (bus32.busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 5) begin
        bus32.control = OP_PASSA;
        bus32.a = 32'hDEAD_BEEF;
        bus32.start = 1'b1;
      end
      tick();
      bus32.start = 1'b0;
      lat++;
    end
    check("multu latency", lat, 34);
    check("multu busy", busy_ok, 1'b1);
    check("multu busy drops", bus32.busy, 1'b0);
    check("multu prod", {bus32.res_mult, bus32.res}, 64'h1_FFFF_FFFE);
    check("multu flags", fl32(), 4'b0000);
    tick();
    check("multu done pulse", bus32.done, 1'b0);
    check("multu res holds", bus32.res, 32'hFFFF_FFFE);

    issue32(OP_MULT, 32'hFFFF_FFFD, 32'h7, 16'h0);
    wait32(lat, busy_ok);
    check("mult neg latency", lat, 34);
    check("mult neg prod", {bus32.res_mult, bus32.res}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult neg flags", fl32(), 4'b0010);

    issue32(OP_MULT, 32'h8000_0000, 32'h8000_0000, 16'h0);
    wait32(lat, busy_ok);
    check("mult min busy", busy_ok, 1'b1);
    check("mult min prod", {bus32.res_mult, bus32.res}, 64'h4000_0000_0000_0000);
    check("mult min flags", fl32(), 4'b0000);

    // Asynchronous reset partway through a multiply.
    sop("pre-rst passa", OP_PASSA, 32'hDEAD_BEEF, 32'h0, 16'h0, 32'hDEAD_BEEF, 4'b0010);
    issue32(OP_MULTU, 32'h1234, 32'h10, 16'h0);
    repeat (9) tick();
    check("rst pre busy", bus32.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst busy/done", {bus32.busy, bus32.done}, 2'b00);
    check("rst res", bus32.res, 32'h0);
    check("rst res_mult", bus32.res_mult, 32'h0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) saw_done = 1'b1;
    end
    check("rst no done", saw_done, 1'b0);
    sop("post-rst addi", OP_ADDI, 32'h5, 32'h0, 16'hFFFF, 32'h0001_0004, 4'b0000);

    // WIDTH=8 instance.
    issue8(OP_MULTU, 8'hFF, 8'hFF, 16'h0);
    wait8(lat);
    check("w8 multu latency", lat, 10);
    check("w8 multu prod", {bus8.res_mult, bus8.res}, 16'hFE01);
    check("w8 multu flags", fl8(), 4'b0010);
    issue8(OP_MULT, 8'h80, 8'h80, 16'h0);
    wait8(lat);
    check("w8 mult min prod", {bus8.res_mult, bus8.res}, 16'h4000);
    issue8(OP_SLLI, 8'h41, 8'h0, 16'h0009);
    check("w8 slli done", bus8.done, 1'b1);
    check("w8 slli res", bus8.res, 8'h82);
    check("w8 slli flags", fl8(), 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the combinational execute-stage ALU of the KGP-RISC core.
- Same 6-bit control encoding.
- Registered results and flags.
- start/done handshake.
- Iterative shift-add multiplier for MULTU/MULT, producing a full 2*WIDTH product.
- Sits in the EX stage; the controller stalls the PC while busy=1.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of two).
SHW, $clog2(WIDTH), shift-amount bits taken from b or imm (derived, not overridden).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-high reset.
start  in  1  request; sampled only when busy=0.
a  in  WIDTH  operand A (rs).
b  in  WIDTH  operand B (rt).
imm  in  16  immediate, zero-extended to WIDTH.
control  in  6  opcode (encoding below).
busy  out  1  multiply in progress; start ignored.
done  out  1  one-cycle pulse: res/flags valid from this cycle.
res  out  WIDTH  result / low product word.
res_mult  out  WIDTH  high product word; 0 for non-multiply ops.
c_flag  out  1  carry.
z_flag  out  1  zero.
s_flag  out  1  sign.
o_flag  out  1  signed overflow.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, res, res_mult and all flags = 0. Reset mid-multiply aborts the operation with no done.
- Operands and control are latched on accept (start & ~busy); later input changes do not affect the operation.
- Opcodes, single-cycle:
  - 010000 and; 010001 xor.
  - 010010 add: {c,res}=a+b.
  - 010101 res=-b.
  - 010110 srl b; 010111 sll b; 011000 sra b (true arithmetic). Shift amount is the low SHW bits of b.
  - 100000 addi: {c,res}=a+zext(imm).
  - 100001 res=-zext(imm).
  - 100010/100011/100100 srl/sll/sra by imm[SHW-1:0].
  - 000000 res=a+zext(imm), address calc, c=o=0.
  - 110000 res=a; 110001 res=b.
  - Any other code: res=0.
- Opcodes, multi-cycle: 010011 multu; 010100 mult (signed).
- Single-cycle ops: result registered at the accept edge; done=1 in the next cycle; state stays IDLE, busy stays 0.
- Multiply FSM: IDLE -> MUL -> SIGN -> IDLE.
  - On accept: load |a|, |b| (raw values for multu), clear the 2W accumulator, counter=0, record neg = a[W-1]^b[W-1] (mult only); busy=1.
  - MUL: one multiplier bit per cycle (add-shift), for exactly WIDTH cycles; counter 0..WIDTH-1, then go to SIGN.
  - SIGN: two's-complement the 2W product if neg. Write {res_mult,res}; done=1 on the following cycle; busy drops with done.
  - Latency: done is asserted WIDTH+2 cycles after the accept edge.
  - -2^(W-1) operands must work: the magnitude is taken as unsigned W bits.
- Flags are updated only when done rises and hold until the next done:
  - z: res==0 for single ops; {res_mult,res}==0 for multiplies.
  - s: res[W-1] for single ops; res_mult[W-1] for multiplies.
  - c: carry out for add/addi; 0 otherwise.
  - o, add: (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1]).
  - o, addi: (a[W-1]==0) & res[W-1].
  - o: 0 for all other ops.
- Handshake:
  - done is a 1-cycle pulse.
  - start in the done cycle is accepted, giving back-to-back single ops one per cycle.
  - start while busy is dropped silently.
  - res/flags hold their values between operations.

Decomposition:
- Shared package alu_pkg: localparam opcode constants (OP_AND, OP_XOR, OP_ADD, OP_MULTU, OP_MULT, OP_NEG, OP_SRL, OP_SLL, OP_SRA, OP_ADDI, OP_NEGI, OP_SRLI, OP_SLLI, OP_SRAI, OP_ADDR, OP_PASSA, OP_PASSB); state enum {IDLE, MUL, SIGN}.
- One sub-module: mul_seq. Holds the iterative multiplier, accumulator and counter, with its own start/done. alu_seq keeps the combinational single-cycle datapath, the flag logic and the top FSM.

Test Plan:
- add, a=0x7FFFFFFF, b=1 -> one cycle later done=1, res=0x80000000, c=0, o=1, s=1, z=0.
- add, a=0xFFFFFFFF, b=1 -> res=0, c=1, z=1, o=0. Next-cycle back-to-back sra, a=0x80000000, b=4 -> res=0xF8000000.
- multu, a=0xFFFFFFFF, b=2 -> done exactly 34 cycles after accept, busy=1 throughout; res_mult=1, res=0xFFFFFFFE. A start pulsed mid-op is ignored.
- mult, a=-3 (0xFFFFFFFD), b=7 -> {res_mult,res}=0xFFFFFFFF_FFFFFFEB, s=1. Also mult, a=0x80000000, b=0x80000000 -> res_mult=0x40000000, res=0.
- rst asserted at cycle 10 of a multu -> busy/done/res immediately 0, no done pulse. A following addi a=5, imm=0xFFFF -> res=0x00010004.
- WIDTH=8 instance: multu 0xFF*0xFF -> {res_mult,res}=0xFE01, latency 10. sll imm=9 -> shift by 1 (low 3 bits).
